// File: rtl/shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_ctrl_pkg
//  Purpose  : Shared definitions for the multi-cycle shift controller:
//             op codes, FSM state encoding, default per-cycle step and an
//             op-legality helper used by both controller and datapath.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

    // Largest shift distance the datapath applies in a single cycle.
    localparam int STEP_DEFAULT = 4;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Codes 101..111 are reserved and reported as errors.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_controller_if
//  Purpose  : Request/response bundle of the shift controller.
//  Ports    : start, op[2:0], data_in[31:0], amount[4:0]  (request side)
//             busy, done, err, result[31:0]                (response side)
//             master - drives requests, slave - the controller itself
//  Revision : 1.0 - initial release
// ============================================================================
interface shift_controller_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [4:0]  amount;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;

    modport master (
        output start, op, data_in, amount,
        input  busy, done, err, result
    );

    modport slave (
        input  start, op, data_in, amount,
        output busy, done, err, result
    );

endinterface
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module   : shift_step
//  Purpose  : Combinational single-step shifter. Applies one shift/rotate of
//             k bits (k never exceeds the controller's STEP) to a 32-bit word.
//  Ports    : word[31:0]    - operand
//             op[2:0]       - operation code
//             k[4:0]        - distance for this step
//             shifted[31:0] - result of the step
//  Revision : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  op,
    input  logic [4:0]  k,
    output logic [31:0] shifted
);

    // Complementary distance for rotates. k==0 gives 32, which shifts the
    // wrapped half out entirely so the rotate degenerates to a pass-through.
    logic [5:0] w_wrap;
    assign w_wrap = 6'd32 - {1'b0, k};

    always_comb begin
        shifted = word;
        case (op)
            OP_SHL:  shifted = word << k;
            OP_SHR:  shifted = word >> k;
            OP_SHRA: shifted = $unsigned($signed(word) >>> k);
            OP_ROL:  shifted = (word << k) | (word >> w_wrap);
            OP_ROR:  shifted = (word >> k) | (word << w_wrap);
            default: shifted = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_controller.sv
`default_nettype none
// ============================================================================
//  Module   : shift_controller
//  Purpose  : Multi-cycle barrel-shift controller. Latches an operation on
//             start, then applies at most STEP bits of shift per cycle until
//             the requested distance is exhausted, and pulses done.
//  Ports    : clock  - rising-edge clock
//             reset  - synchronous active-high reset
//             bus    - shift_controller_if.slave (start/op/data_in/amount in,
//                      busy/done/err/result out)
//  Params   : STEP   - max bits shifted per cycle (1, 2, 4, 8 or 16)
//  Revision : 1.0 - initial release
// ============================================================================
module shift_controller
    import shift_ctrl_pkg::*;
#(
    parameter int STEP = STEP_DEFAULT
)
(
    input  logic                 clock,
    input  logic                 reset,
    shift_controller_if.slave    bus
);

    localparam logic [4:0] STEP_K = 5'(STEP);

    state_e      r_state;
    logic [31:0] r_word;
    logic [2:0]  r_op;
    logic [4:0]  r_remaining;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_result;

    logic [4:0]  w_k;
    logic [4:0]  w_rem_next;
    logic [31:0] w_step_word;

    // Distance applied this cycle: whatever is left, capped at STEP.
    assign w_k        = (r_remaining < STEP_K) ? r_remaining : STEP_K;
    assign w_rem_next = r_remaining - w_k;

    shift_step u_shift_step (
        .word    (r_word),
        .op      (r_op),
        .k       (w_k),
        .shifted (w_step_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_word      <= 32'd0;
            r_op        <= 3'd0;
            r_remaining <= 5'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (bus.start) begin
                        r_word      <= bus.data_in;
                        r_op        <= bus.op;
                        r_remaining <= bus.amount;
                        r_busy      <= 1'b1;
                        // Nothing to shift (zero distance or bad op): the
                        // operand is the answer and no RUN cycle is spent.
                        if ((bus.amount == 5'd0) || !op_is_legal(bus.op)) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_err    <= !op_is_legal(bus.op);
                            r_result <= bus.data_in;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    r_word      <= w_step_word;
                    r_remaining <= w_rem_next;
                    if (w_rem_next == 5'd0) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_step_word;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here.
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_controller
//  Purpose  : Self-checking bench for shift_controller (STEP=4). Stimulus
//             pushes expected {result, err, latency} into a queue; a monitor
//             pops and compares on every done pulse.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_controller;
    import shift_ctrl_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t q[$];
    exp_t m_e;

    shift_controller_if bus ();

    shift_controller #(.STEP(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: actual done=1 result=%h required no done", bus.result);
            end else begin
                m_e = q.pop_front();
                check("result",  bus.result, m_e.res);
                check("err",     {31'd0, bus.err}, {31'd0, m_e.err});
                check("latency", 32'(cyc - m_e.t0 + 1), 32'(m_e.lat));
            end
        end
    end

    // Called at a negedge while the DUT is idle; start is sampled at the
    // next rising edge, which becomes cycle count cyc+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                         input logic [31:0] r, input logic e, input int lat, input bit expect_done);
        exp_t ex;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.data_in = d;
        bus.amount  = a;
        if (expect_done) begin
            ex.res = r;
            ex.err = e;
            ex.t0  = cyc + 1;
            ex.lat = lat;
            q.push_back(ex);
        end
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (bus.busy) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: actual busy=1 after %0d cycles required busy=0", n);
        end
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{OP_SHL,  32'hA5A5A5A5, 5'd1,  32'h4B4B4B4A, 1'b0, 2};
        vecs[1]  = '{OP_SHL,  32'hDEADBEEF, 5'd2,  32'h7AB6FBBC, 1'b0, 2};
        vecs[2]  = '{OP_SHRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 9};
        vecs[3]  = '{OP_SHR,  32'h80000000, 5'd31, 32'h00000001, 1'b0, 9};
        vecs[4]  = '{OP_ROL,  32'h12345678, 5'd8,  32'h34567812, 1'b0, 3};
        vecs[5]  = '{OP_ROR,  32'h87654321, 5'd16, 32'h43218765, 1'b0, 5};
        vecs[6]  = '{OP_SHL,  32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF, 1'b0, 1};
        vecs[7]  = '{3'b111,  32'h13579BDF, 5'd5,  32'h13579BDF, 1'b1, 1};
        vecs[8]  = '{OP_ROR,  32'h00000001, 5'd5,  32'h08000000, 1'b0, 3};
        vecs[9]  = '{OP_SHRA, 32'h7FFFFFFF, 5'd4,  32'h07FFFFFF, 1'b0, 2};
        vecs[10] = '{OP_ROL,  32'h80000001, 5'd1,  32'h00000003, 1'b0, 2};
        vecs[11] = '{3'b101,  32'hCAFEF00D, 5'd0,  32'hCAFEF00D, 1'b1, 1};
        vecs[12] = '{OP_SHR,  32'hF0000000, 5'd17, 32'h00007800, 1'b0, 6};
        vecs[13] = '{OP_ROL,  32'h0000000F, 5'd31, 32'h80000007, 1'b0, 9};
        vecs[14] = '{OP_SHL,  32'h00000001, 5'd4,  32'h00000010, 1'b0, 2};
    end

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.data_in = 32'd0;
        bus.amount  = 5'd0;
        repeat (3) @(negedge clock);
        check("reset_busy",   {31'd0, bus.busy}, 32'd0);
        check("reset_done",   {31'd0, bus.done}, 32'd0);
        check("reset_err",    {31'd0, bus.err},  32'd0);
        check("reset_result", bus.result,        32'd0);
        reset = 1'b0;

        // Directed vectors, issued back to back.
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].res, vecs[i].err, vecs[i].lat, 1'b1);
            wait_idle();
        end

        // Result holds across idle cycles.
        repeat (3) @(negedge clock);
        check("hold_idle", bus.result, 32'h00000010);

        // Starts during RUN and during DONE are ignored.
        issue(OP_SHL, 32'h00000001, 5'd20, 32'h00100000, 1'b0, 6, 1'b1);
        check("busy_in_run", {31'd0, bus.busy}, 32'd1);
        check("hold_in_run", bus.result, 32'h00000010);
        bus.start   = 1'b1;
        bus.op      = OP_ROR;
        bus.data_in = 32'hFFFF0000;
        bus.amount  = 5'd3;
        for (int n = 0; n < 20 && bus.done !== 1'b1; n++) @(negedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        check("no_accept_after_done", {31'd0, bus.busy}, 32'd0);
        check("hold_after_ignored", bus.result, 32'h00100000);

        // Reset during the second RUN cycle.
        issue(OP_SHL, 32'h00000001, 5'd20, 32'd0, 1'b0, 0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_busy",   {31'd0, bus.busy}, 32'd0);
        check("midrun_reset_result", bus.result,        32'd0);
        reset = 1'b0;
        issue(OP_ROL, 32'h12345678, 5'd8, 32'h34567812, 1'b0, 3, 1'b1);
        wait_idle();
        repeat (2) @(negedge clock);

        check("pending_left", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        compared++;
        mismatched++;
        $display("FAIL watchdog: actual simulation still running required finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
